aes_key_schedule: RTL

- Upstream feeder for the AES-128 decryption round stages. Each round stage takes a 128-bit round_key.
- Expands one 128-bit cipher key into the 11 round keys, one full round key per clock.
- Stores all 11 keys in an internal buffer and serves them through an indexed read port, so the InvAddRoundKey step of each round can fetch its key (round 10 first for decryption).

---
 rtl/aes_key_schedule.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion with an 11-entry round-key buffer and a registered
// indexed read port. One round key is produced per clock; decryption stages
// fetch their keys by round index once the full set is present.
module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [0:127] cipher_key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [0:127] round_key
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // Forward AES S-box, row-major: entry 16*hi + lo
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, GEN} state_t;

  state_t       state, next_state;
  logic         load_key, gen_step, finish;

  logic [0:127] work;
  logic [7:0]   rcon;
  logic [3:0]   round_cnt;
  logic [0:127] key_buf [0:NUM_ROUNDS];

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [0:127] next_work;
  logic [7:0]   rcon_next;

  // One expansion step on the working key: word 0 takes the rotated,
  // substituted last word plus rcon; the rest chain through the new words.
  assign w0    = work[0:31];
  assign w1    = work[32:63];
  assign w2    = work[64:95];
  assign w3    = work[96:127];
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                  SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
  assign n0    = w0 ^ sub_w ^ {rcon, 24'h000000};
  assign n1    = w1 ^ n0;
  assign n2    = w2 ^ n1;
  assign n3    = w3 ^ n2;
  assign next_work = {n0, n1, n2, n3};
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and step controls: accept start only when idle, finish on the last round
  always_comb begin
    next_state = state;
    load_key   = 1'b0;
    gen_step   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_key   = 1'b1;
          next_state = GEN;
        end
      end
      GEN: begin
        gen_step = 1'b1;
        if (round_cnt == LAST_ROUND) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Working key, rcon, round counter, status flags and the gated read register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      work       <= '0;
      rcon       <= 8'h00;
      round_cnt  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      round_key  <= '0;
    end else begin
      if (load_key) begin
        work      <= cipher_key;
        rcon      <= 8'h01;
        round_cnt <= 4'd1;
      end else if (gen_step) begin
        work      <= next_work;
        rcon      <= rcon_next;
        round_cnt <= finish ? 4'd0 : round_cnt + 4'd1;
      end
      busy <= (next_state == GEN);
      done <= finish;
      if (load_key)    keys_valid <= 1'b0;
      else if (finish) keys_valid <= 1'b1;
      if (keys_valid && !load_key && (rd_round <= LAST_ROUND))
        round_key <= key_buf[rd_round];
      else
        round_key <= '0;
    end
  end

  // Key buffer: slot 0 takes the cipher key, slot k the k-th generated key
  always_ff @(posedge Clk) begin
    if (load_key)
      key_buf[0] <= cipher_key;
    else if (gen_step)
      key_buf[round_cnt] <= next_work;
  end

endmodule
